// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: turns core load/store requests into variable-latency bus transactions.
// Optional posted-write buffer enabled by defining DMEM_WBUF_EN.
module dmem_bridge #(
  parameter int              XLEN     = 32,
  parameter int              TIMEOUT  = 16,
  parameter logic [XLEN-1:0] ERR_DATA = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [3:0]      be_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            stall_o,
  output logic            err_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [XLEN-1:0] bus_wdata_o,
  output logic [3:0]      bus_be_o,
  input  logic            bus_ack_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  input  logic            bus_err_i
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

`ifdef DMEM_WBUF_EN
  typedef enum logic [1:0] {IDLE, REQ, RESP, WBUSY} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            stall, req, access, timed_out;

  assign access    = mem_read_i | mem_write_i;
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          // Write wins when both strobes are set; reads always fetch the whole word.
          addr_d  = addr_i & ~XLEN'(3);
          wdata_d = wdata_i;
          be_d    = mem_write_i ? be_i : 4'hF;
          we_d    = mem_write_i;
          cnt_d   = '0;
          stall   = 1'b1;
          state_d = REQ;
`ifdef DMEM_WBUF_EN
          if (mem_write_i) begin
            stall   = 1'b0;
            state_d = WBUSY;
          end
`endif
        end
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (bus_ack_i) begin
          rdata_d = bus_err_i ? ERR_DATA : bus_rdata_i;
          err_d   = bus_err_i;
          state_d = RESP;
        end else if (timed_out) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
`ifdef DMEM_WBUF_EN
      WBUSY: begin
        // Posted write in flight: hold off any new access until it retires.
        req   = 1'b1;
        stall = access;
        cnt_d = cnt_q + 1'b1;
        if (bus_ack_i) begin
          err_d   = bus_err_i;
          state_d = IDLE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall is gated so the core sees no freeze while reset is held.
  assign stall_o     = stall & reset;
  assign bus_req_o   = req;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_be_o    = be_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: expected bus transactions are queued at issue
// and compared when the modelled bus acknowledges them.
module tb_dmem_bridge;
  localparam int          XLEN    = 32;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERRD    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata_o;
  logic        stall_o, err_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  logic        ack_en = 1'b0;
  logic        force_ack = 1'b0;
  int          wait_cyc = 0;
  int          reqcyc = 0;

  int nchk = 0;
  int nerr = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_txn_t;

  bus_txn_t exp_q[$];
  bus_txn_t mon_e;

  int stalls, reqs;

  always #5 clk = ~clk;

  dmem_bridge #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset(reset),
    .mem_read_i(mem_read), .mem_write_i(mem_write),
    .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
  );

  // Bus model: ack in the wait_cyc-th (0-based) cycle of a request.
  always @(posedge clk) begin
    if (bus_req_o) reqcyc <= reqcyc + 1;
    else           reqcyc <= 0;
  end
  assign bus_ack = force_ack | (bus_req_o & ack_en & (reqcyc == wait_cyc));

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus_req_o && bus_ack) begin
      if (exp_q.size() == 0) begin
        check_val("bus_unexpected_txn", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("bus_we", {31'd0, bus_we_o}, {31'd0, mon_e.we});
        check_val("bus_addr", bus_addr_o, mon_e.addr);
        check_val("bus_be", {28'd0, bus_be_o}, {28'd0, mon_e.be});
        if (mon_e.we) check_val("bus_wdata", bus_wdata_o, mon_e.wdata);
      end
    end
  end

  // Present an access, run it until the stall drops (RESP), count stall and request cycles.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] b, input int wc,
                            input logic ack_it, input logic berr, input logic [31:0] brd);
    bus_txn_t t;
    t.we    = wr;
    t.addr  = {a[31:2], 2'b00};
    t.be    = wr ? b : 4'hF;
    t.wdata = wd;
    if (ack_it) exp_q.push_back(t);
    wait_cyc  = wc;
    ack_en    = ack_it;
    bus_err   = berr;
    bus_rdata = brd;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; be = b;
    stalls = 0; reqs = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall_o) break;
      stalls++;
      if (bus_req_o) reqs++;
      @(negedge clk);
    end
  endtask

  task automatic end_access();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check_val("err_pulse_width", {31'd0, err_o}, 32'd0);
    check_val("idle_stall", {31'd0, stall_o}, 32'd0);
  endtask

  initial begin
    #12;
    check_val("rst_rdata", rdata_o, 32'd0);
    check_val("rst_stall", {31'd0, stall_o}, 32'd0);
    check_val("rst_err", {31'd0, err_o}, 32'd0);
    check_val("rst_req", {31'd0, bus_req_o}, 32'd0);
    check_val("rst_we", {31'd0, bus_we_o}, 32'd0);
    check_val("rst_addr", bus_addr_o, 32'd0);
    check_val("rst_be", {28'd0, bus_be_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Load, ack in third request cycle.
    run_access(1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'h0, 2, 1'b1, 1'b0, 32'hCAFE_F00D);
    check_val("ld_stalls", stalls, 32'd4);
    check_val("ld_rdata", rdata_o, 32'hCAFE_F00D);
    check_val("ld_err", {31'd0, err_o}, 32'd0);
    end_access();

    // Store, ack in first request cycle.
    run_access(1'b0, 1'b1, 32'h0000_2000, 32'h1122_3344, 4'b0011, 0, 1'b1, 1'b0, 32'h0);
    check_val("st_stalls", stalls, 32'd2);
    end_access();

    // Ack seen outside REQ must not change rdata or raise err.
    bus_rdata = 32'h5555_AAAA;
    run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 1'b1, 1'b0, 32'h0BAD_F00D);
    check_val("ld2_rdata", rdata_o, 32'h0BAD_F00D);
    end_access();
    bus_rdata = 32'h5555_AAAA;
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    #1;
    check_val("stray_ack_rdata", rdata_o, 32'h0BAD_F00D);
    check_val("stray_ack_err", {31'd0, err_o}, 32'd0);

    // Timeout: no ack ever.
    run_access(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h0);
    check_val("to_reqs", reqs, TIMEOUT);
    check_val("to_stalls", stalls, TIMEOUT + 1);
    check_val("to_rdata", rdata_o, ERRD);
    check_val("to_err", {31'd0, err_o}, 32'd1);
    end_access();

    // Bus error ack.
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h7777_0000);
    end_access();
    run_access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'h0, 1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check_val("berr_stalls", stalls, 32'd3);
    check_val("berr_rdata", rdata_o, ERRD);
    check_val("berr_err", {31'd0, err_o}, 32'd1);
    end_access();

    // Read and write together: write wins.
    run_access(1'b1, 1'b1, 32'h0000_4003, 32'hA5A5_5A5A, 4'b1100, 1, 1'b1, 1'b0, 32'h0);
    check_val("rw_stalls", stalls, 32'd3);
    end_access();

    // Store with no byte enables still goes out.
    run_access(1'b0, 1'b1, 32'h0000_5008, 32'h0102_0304, 4'b0000, 0, 1'b1, 1'b0, 32'h0);
    check_val("be0_stalls", stalls, 32'd2);
    end_access();

    // Reset in the middle of a request.
    run_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h1234_5678);
    check_val("pre_rst_rdata", rdata_o, 32'h1234_5678);
    end_access();
    ack_en = 1'b0;
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h0000_0024;
    repeat (3) @(negedge clk);
    #1;
    check_val("in_req", {31'd0, bus_req_o}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_val("arst_req", {31'd0, bus_req_o}, 32'd0);
    check_val("arst_stall", {31'd0, stall_o}, 32'd0);
    check_val("arst_rdata", rdata_o, 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    reset = 1'b1;
    run_access(1'b1, 1'b0, 32'h0000_0028, 32'h0, 4'h0, 1, 1'b1, 1'b0, 32'h89AB_CDEF);
    check_val("post_rst_stalls", stalls, 32'd3);
    check_val("post_rst_rdata", rdata_o, 32'h89AB_CDEF);
    end_access();

`ifdef DMEM_WBUF_EN
    // Posted store followed by a load on the next cycle.
    begin
      bus_txn_t tw, tr;
      tw.we = 1'b1; tw.addr = 32'h0000_6000; tw.be = 4'hF; tw.wdata = 32'hFEED_0001;
      tr.we = 1'b0; tr.addr = 32'h0000_6104; tr.be = 4'hF; tr.wdata = 32'h0;
      exp_q.push_back(tw);
      exp_q.push_back(tr);
      wait_cyc = 5; ack_en = 1'b1; bus_err = 1'b0; bus_rdata = 32'h0F0F_0F0F;
      @(negedge clk);
      mem_write = 1'b1; addr = 32'h0000_6000; wdata = 32'hFEED_0001; be = 4'hF;
      #1;
      check_val("wb_store_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      mem_write = 1'b0; mem_read = 1'b1; addr = 32'h0000_6104;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
        #1;
        if (!stall_o) break;
        stalls++;
        @(negedge clk);
      end
      check_val("wb_load_stalls", stalls, 32'd13);
      check_val("wb_load_rdata", rdata_o, 32'h0F0F_0F0F);
      end_access();
    end
`endif

    repeat (2) @(negedge clk);
    check_val("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
